// File: rtl/ifid_decode_reg.sv
// IF/ID pipeline register with LEGv8 immediate-class pre-decode.
// One-entry elastic buffer; decode is combinational from Instr.
module ifid_decode_reg (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        InValid,
  output logic        InReady,
  input  logic [31:0] Instr,
  input  logic [63:0] PCIn,
  input  logic        Flush,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [25:0] Imm26,
  output logic [1:0]  SignOp,
  output logic        ImmUsed,
  output logic        Illegal,
  output logic [63:0] PCOut,
  output logic [31:0] InstrOut
);

  typedef enum logic [1:0] {
    SOP_I  = 2'd0,
    SOP_D  = 2'd1,
    SOP_B  = 2'd2,
    SOP_CB = 2'd3
  } sop_e;

  typedef struct packed {
    logic [25:0] imm;
    sop_e        sop;
    logic        used;
    logic        ill;
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic [10:0] op;
  sop_e        dec_sop;
  logic        dec_used;
  logic        dec_ill;
  logic        load;
  logic        valid_d;
  logic        valid_q;
  ent_t        ent_d;
  ent_t        ent_q;

  assign op = Instr[31:21];

  // Opcode classification into extender format and legality.
  always_comb begin
    dec_sop  = SOP_I;
    dec_used = 1'b0;
    dec_ill  = 1'b0;
    unique casez (op)
      11'b1001000100?,
      11'b1011000100?,
      11'b1101000100?,
      11'b1111000100?,
      11'b1001001000?,
      11'b1011001000?,
      11'b1101001000?: begin
        dec_sop  = SOP_I;
        dec_used = 1'b1;
      end
      11'b11111000010,
      11'b11111000000: begin
        dec_sop  = SOP_D;
        dec_used = 1'b1;
      end
      11'b000101?????,
      11'b100101?????: begin
        dec_sop  = SOP_B;
        dec_used = 1'b1;
      end
      11'b10110100???,
      11'b10110101???,
      11'b01010100???: begin
        dec_sop  = SOP_CB;
        dec_used = 1'b1;
      end
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000,
      11'b11001010000,
      11'b11010011011,
      11'b11010011010,
      11'b11010110000: begin
        dec_sop  = SOP_I;
        dec_used = 1'b0;
      end
      default: begin
        dec_sop  = SOP_I;
        dec_used = 1'b0;
        dec_ill  = 1'b1;
      end
    endcase
  end

  assign InReady = ~valid_q | OutReady;
  assign load    = InValid & InReady & ~Flush;

  // Next entry: flush beats load, load beats drain, else hold.
  always_comb begin
    valid_d = valid_q;
    ent_d   = ent_q;
    if (Flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d     = 1'b1;
      ent_d.imm   = Instr[25:0];
      ent_d.sop   = dec_sop;
      ent_d.used  = dec_used;
      ent_d.ill   = dec_ill;
      ent_d.pc    = PCIn;
      ent_d.instr = Instr;
    end else if (valid_q & OutReady) begin
      valid_d = 1'b0;
    end
  end

  // Entry register; reset clears everything and drops any held entry.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      valid_q <= 1'b0;
      ent_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ent_q   <= ent_d;
    end
  end

  assign OutValid = valid_q;
  assign Imm26    = ent_q.imm;
  assign SignOp   = ent_q.sop;
  assign ImmUsed  = ent_q.used;
  assign Illegal  = ent_q.ill;
  assign PCOut    = ent_q.pc;
  assign InstrOut = ent_q.instr;

endmodule

// File: tb/tb_ifid_decode_reg.sv
// Randomized and directed bench for ifid_decode_reg.
// Reference model: opcode rule table plus one-entry buffer semantics.
module tb_ifid_decode_reg;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        InValid;
  logic        InReady;
  logic [31:0] Instr;
  logic [63:0] PCIn;
  logic        Flush;
  logic        OutValid;
  logic        OutReady;
  logic [25:0] Imm26;
  logic [1:0]  SignOp;
  logic        ImmUsed;
  logic        Illegal;
  logic [63:0] PCOut;
  logic [31:0] InstrOut;

  always #5 Clk = ~Clk;

  ifid_decode_reg dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .InValid  (InValid),
    .InReady  (InReady),
    .Instr    (Instr),
    .PCIn     (PCIn),
    .Flush    (Flush),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Imm26    (Imm26),
    .SignOp   (SignOp),
    .ImmUsed  (ImmUsed),
    .Illegal  (Illegal),
    .PCOut    (PCOut),
    .InstrOut (InstrOut)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [10:0] pat;
    logic [10:0] care;
    logic [1:0]  sop;
    logic        used;
  } rule_t;

  rule_t rules[$];

  task automatic add_rule(input logic [10:0] p, input logic [10:0] c,
                          input logic [1:0] s, input logic u);
    rule_t r;
    r.pat  = p;
    r.care = c;
    r.sop  = s;
    r.used = u;
    rules.push_back(r);
  endtask

  task automatic build_rules();
    logic [10:0] fi;
    logic [10:0] fa;
    logic [10:0] fb;
    logic [10:0] fc;
    fi = 11'h7FE;
    fa = 11'h7FF;
    fb = 11'h7E0;
    fc = 11'h7F8;
    add_rule(11'b10010001000, fi, 2'd0, 1'b1);
    add_rule(11'b10110001000, fi, 2'd0, 1'b1);
    add_rule(11'b11010001000, fi, 2'd0, 1'b1);
    add_rule(11'b11110001000, fi, 2'd0, 1'b1);
    add_rule(11'b10010010000, fi, 2'd0, 1'b1);
    add_rule(11'b10110010000, fi, 2'd0, 1'b1);
    add_rule(11'b11010010000, fi, 2'd0, 1'b1);
    add_rule(11'b11111000010, fa, 2'd1, 1'b1);
    add_rule(11'b11111000000, fa, 2'd1, 1'b1);
    add_rule(11'b00010100000, fb, 2'd2, 1'b1);
    add_rule(11'b10010100000, fb, 2'd2, 1'b1);
    add_rule(11'b10110100000, fc, 2'd3, 1'b1);
    add_rule(11'b10110101000, fc, 2'd3, 1'b1);
    add_rule(11'b01010100000, fc, 2'd3, 1'b1);
    add_rule(11'b10001011000, fa, 2'd0, 1'b0);
    add_rule(11'b11001011000, fa, 2'd0, 1'b0);
    add_rule(11'b10001010000, fa, 2'd0, 1'b0);
    add_rule(11'b10101010000, fa, 2'd0, 1'b0);
    add_rule(11'b11001010000, fa, 2'd0, 1'b0);
    add_rule(11'b11010011011, fa, 2'd0, 1'b0);
    add_rule(11'b11010011010, fa, 2'd0, 1'b0);
    add_rule(11'b11010110000, fa, 2'd0, 1'b0);
  endtask

  task automatic ref_decode(input logic [31:0] w,
                            output logic [1:0] s,
                            output logic u,
                            output logic il);
    s  = 2'd0;
    u  = 1'b0;
    il = 1'b1;
    foreach (rules[i]) begin
      if (((w[31:21] ^ rules[i].pat) & rules[i].care) == 11'd0) begin
        s  = rules[i].sop;
        u  = rules[i].used;
        il = 1'b0;
      end
    end
  endtask

  // Model state: what the stage should be presenting.
  logic        m_v;
  logic [25:0] m_imm;
  logic [1:0]  m_sop;
  logic        m_used;
  logic        m_ill;
  logic [63:0] m_pc;
  logic [31:0] m_instr;

  task automatic model_reset();
    m_v     = 1'b0;
    m_imm   = '0;
    m_sop   = '0;
    m_used  = 1'b0;
    m_ill   = 1'b0;
    m_pc    = '0;
    m_instr = '0;
  endtask

  task automatic check_outputs();
    check("valid", 64'(OutValid), 64'(m_v));
    check("imm26", 64'(Imm26), 64'(m_imm));
    check("signop", 64'(SignOp), 64'(m_sop));
    check("immused", 64'(ImmUsed), 64'(m_used));
    check("illegal", 64'(Illegal), 64'(m_ill));
    check("pcout", PCOut, m_pc);
    check("instrout", 64'(InstrOut), 64'(m_instr));
  endtask

  // One cycle: check at negedge, drive, then advance model at posedge.
  task automatic step(input logic v, input logic [31:0] ins,
                      input logic [63:0] pc, input logic fl,
                      input logic ordy, input logic rn);
    logic accept;
    @(negedge Clk);
    check_outputs();
    InValid  = v;
    Instr    = ins;
    PCIn     = pc;
    Flush    = fl;
    OutReady = ordy;
    Reset_n  = rn;
    #1;
    accept = !m_v || ordy;
    check("inready", 64'(InReady), 64'(accept));
    @(posedge Clk);
    if (!rn) begin
      model_reset();
    end else if (fl) begin
      m_v = 1'b0;
    end else if (v && accept) begin
      m_v     = 1'b1;
      m_imm   = ins[25:0];
      m_pc    = pc;
      m_instr = ins;
      ref_decode(ins, m_sop, m_used, m_ill);
    end else if (m_v && ordy) begin
      m_v = 1'b0;
    end
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    int k;
    logic [10:0] op;
    k = $urandom_range(0, 22);
    if (k == 22)
      return $urandom;
    op = (rules[k].pat & rules[k].care) |
         (11'($urandom) & ~rules[k].care);
    return {op, 21'($urandom)};
  endfunction

  initial begin
    logic [31:0] sweep_i[4];
    logic [1:0]  sweep_s[4];
    logic        sweep_u[4];
    logic        sweep_l[4];
    build_rules();
    Reset_n  = 1'b0;
    InValid  = 1'b0;
    Instr    = '0;
    PCIn     = '0;
    Flush    = 1'b0;
    OutReady = 1'b0;
    repeat (2) @(posedge Clk);
    model_reset();

    // Reset state then ADDI single load.
    step(1'b1, 32'h91000C41, 64'h40, 1'b0, 1'b1, 1'b1);
    check("addi_v", 64'(OutValid), 64'h1);
    check("addi_sop", 64'(SignOp), 64'h0);
    check("addi_used", 64'(ImmUsed), 64'h1);
    check("addi_imm", 64'(Imm26), 64'h1000C41);
    check("addi_pc", PCOut, 64'h40);

    // Back-pressure on LDUR.
    step(1'b1, 32'hF8408020, 64'h80, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, $urandom, 64'h84, 1'b0, 1'b0, 1'b1);
      check("bp_sop", 64'(SignOp), 64'h1);
      check("bp_instr", 64'(InstrOut), 64'hF8408020);
      check("bp_rdy", 64'(InReady), 64'h0);
    end
    step(1'b1, 32'h91000C41, 64'h88, 1'b0, 1'b1, 1'b1);
    check("bp_next_v", 64'(OutValid), 64'h1);
    check("bp_next_i", 64'(InstrOut), 64'h91000C41);
    check("bp_next_pc", PCOut, 64'h88);

    // Type sweep.
    sweep_i = '{32'h14000010, 32'hB4000041, 32'h8B020020, 32'h0};
    sweep_s = '{2'd2, 2'd3, 2'd0, 2'd0};
    sweep_u = '{1'b1, 1'b1, 1'b0, 1'b0};
    sweep_l = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, sweep_i[i], 64'(i * 4), 1'b0, 1'b1, 1'b1);
      check("sw_sop", 64'(SignOp), 64'(sweep_s[i]));
      check("sw_used", 64'(ImmUsed), 64'(sweep_u[i]));
      check("sw_ill", 64'(Illegal), 64'(sweep_l[i]));
      check("sw_v", 64'(OutValid), 64'h1);
    end

    // Flush over a held entry.
    step(1'b1, 32'h8B020020, 64'h100, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'h14000010, 64'h108, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hB4000041, 64'h110, 1'b1, 1'b0, 1'b1);
    check("fl_v", 64'(OutValid), 64'h0);
    check("fl_instr", 64'(InstrOut), 64'h8B020020);

    // Reset mid-operation.
    step(1'b1, 32'h91000C41, 64'h200, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hF8408020, 64'h204, 1'b0, 1'b0, 1'b0);
    check("rst_v", 64'(OutValid), 64'h0);
    check("rst_pc", PCOut, 64'h0);
    check("rst_instr", 64'(InstrOut), 64'h0);
    step(1'b1, 32'hF8408020, 64'h208, 1'b0, 1'b1, 1'b1);
    check("rst_resume_v", 64'(OutValid), 64'h1);
    check("rst_resume_pc", PCOut, 64'h208);

    // Streaming 20 back-to-back.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, rand_instr(), 64'h1000 + 64'(i * 4),
           1'b0, 1'b1, 1'b1);
      check("st_v", 64'(OutValid), 64'h1);
      check("st_pc", PCOut, 64'h1000 + 64'(i * 4));
    end

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(),
           {$urandom, $urandom},
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 39) != 0);
    end
    step(1'b0, 32'h0, 64'h0, 1'b0, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
